// File: rtl/tc_mem_master.sv
// Block-transfer bus master for TC-style single-port memories: turns address/length
// commands into load/save strobes and moves words to/from ready/valid streams.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// READ  | issuing loads while FIFO credit allows
// DRAIN | all loads issued, waiting for in-flight words and FIFO to empty
// WRITE | accepting write words, one save strobe per word
// DONE  | one-cycle completion pulse
module tc_mem_master #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [15:0]          cmd_addr,
  input  logic [15:0]          cmd_len,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [BIT_WIDTH-1:0] rd_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [BIT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_load,
  output logic                 mem_save,
  output logic [15:0]          mem_address,
  output logic [BIT_WIDTH-1:0] mem_in,
  input  logic [BIT_WIDTH-1:0] mem_out
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t               state, state_nxt;
  logic [15:0]          cur_addr, cur_addr_nxt;
  logic [15:0]          remaining, remaining_nxt;
  logic                 mem_load_nxt, mem_save_nxt;
  logic [15:0]          mem_address_nxt;
  logic [BIT_WIDTH-1:0] mem_in_nxt;

  // infl[0] mirrors mem_load (sampled next edge), infl[1] marks mem_out valid to capture
  logic [1:0]           infl;
  logic [BIT_WIDTH-1:0] fifo [4];
  logic [1:0]           wptr, rptr;
  logic [2:0]           count;
  logic [2:0]           occupancy;
  logic                 issue, wr_acc, push, pop;

  assign push      = infl[1];
  assign pop       = rd_valid && rd_ready;
  assign rd_valid  = (count != 3'd0);
  assign rd_data   = rd_valid ? fifo[rptr] : '0;
  assign occupancy = count + {2'b00, infl[0]} + {2'b00, infl[1]};
  assign issue     = (state == READ) && (remaining != 16'd0) && (occupancy < 3'd4);
  assign wr_ready  = (state == WRITE) && (remaining != 16'd0);
  assign wr_acc    = wr_valid && wr_ready;
  assign cmd_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt       = state;
    cur_addr_nxt    = cur_addr;
    remaining_nxt   = remaining;
    mem_load_nxt    = 1'b0;
    mem_save_nxt    = 1'b0;
    mem_address_nxt = mem_address;
    mem_in_nxt      = mem_in;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_nxt  = cmd_addr;
          remaining_nxt = cmd_len;
          if (cmd_len == 16'd0) state_nxt = DONE;
          else if (cmd_write)   state_nxt = WRITE;
          else                  state_nxt = READ;
        end
      end
      READ: begin
        if (issue) begin
          mem_load_nxt    = 1'b1;
          mem_address_nxt = cur_addr;
          cur_addr_nxt    = cur_addr + 16'd1;
          remaining_nxt   = remaining - 16'd1;
          if (remaining == 16'd1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (infl == 2'b00 && count == 3'd0) state_nxt = DONE;
      end
      WRITE: begin
        if (wr_acc) begin
          mem_save_nxt    = 1'b1;
          mem_address_nxt = cur_addr;
          mem_in_nxt      = wr_data;
          cur_addr_nxt    = cur_addr + 16'd1;
          remaining_nxt   = remaining - 16'd1;
          if (remaining == 16'd1) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= 16'd0;
      remaining   <= 16'd0;
      mem_load    <= 1'b0;
      mem_save    <= 1'b0;
      mem_address <= 16'd0;
      mem_in      <= '0;
      infl        <= 2'b00;
      wptr        <= 2'd0;
      rptr        <= 2'd0;
      count       <= 3'd0;
    end else begin
      state       <= state_nxt;
      cur_addr    <= cur_addr_nxt;
      remaining   <= remaining_nxt;
      mem_load    <= mem_load_nxt;
      mem_save    <= mem_save_nxt;
      mem_address <= mem_address_nxt;
      mem_in      <= mem_in_nxt;
      infl        <= {infl[0], issue};
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      count       <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // Storage needs no reset: rd_data is gated by rd_valid and pointers reset.
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= mem_out;
  end

endmodule

// File: doc/tc_mem_master.md
# tc_mem_master

Bus-master engine for the TC-style single-port memory components (registered-read, negedge-write ROM/RAM). It accepts block commands (base address, word count, direction), drives the memory's load/save/address/in pins, and moves data between memory and ready/valid streams. It sits between a CPU/loader core and a memory instance and hides the memory's two-cycle read turnaround and negedge write timing from the core.

## Interface

- BIT_WIDTH, 16, memory/stream data width
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine accepts command (high only in IDLE)
- cmd_write  in  1  1 = write memory from wr stream, 0 = read memory to rd stream
- cmd_addr  in  16  first word address
- cmd_len  in  16  number of words; 0 = no-op
- rd_valid  out  1  read word available
- rd_ready  in  1  consumer accepts read word
- rd_data  out  BIT_WIDTH  read word
- wr_valid  in  1  write word offered
- wr_ready  out  1  engine accepts write word
- wr_data  in  BIT_WIDTH  write word
- busy  out  1  command in progress (any state but IDLE)
- done  out  1  one-cycle pulse on command completion
- mem_load  out  1  to memory load
- mem_save  out  1  to memory save
- mem_address  out  16  to memory address
- mem_in  out  BIT_WIDTH  to memory data in
- mem_out  in  BIT_WIDTH  from memory data out (reads 0 when load low)

## Operation

- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/dir. len=0 -> DONE. cmd_write=1 -> WRITE, else READ.
- READ: each cycle the issue condition holds (remaining>0 and fifo_count+inflight<4), register mem_load=1, mem_address=cur_addr; cur_addr+=1; remaining-=1. Otherwise mem_load=0. When remaining reaches 0 -> DRAIN.
- Capture: a load issued in cycle k is sampled by the memory at edge k+1; mem_out is captured into the 4-entry read FIFO at edge k+2. Track in-flight issues with a 2-stage valid shift register, not a counter of edges.
- Read FIFO: 4 entries, first-word-fall-through onto rd_data/rd_valid; pop on rd_valid&&rd_ready. Credit rule guarantees no overflow; bench asserts none.
- DRAIN: mem_load=0; wait until inflight=0 and FIFO empty -> DONE.
- WRITE: wr_ready=1 while remaining>0. On wr_valid&&wr_ready, register mem_save=1, mem_address=cur_addr, mem_in=wr_data for exactly one cycle (memory writes on the following falling edge); cur_addr+=1, remaining-=1. No accept -> mem_save=0. Last word accepted -> DONE (the save pulse completes during the DONE cycle).
- DONE: done=1 for one cycle, mem_load/mem_save=0, -> IDLE.
- Address arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000. remaining is 16-bit; len=0xFFFF is legal.
- mem_load and mem_save are never high in the same cycle. mem_address/mem_in hold their last value when strobes are low.
- Reset (rst_n low, any time, async): state=IDLE, FIFO and in-flight cleared, cmd_ready=0 while in reset then 1, all other outputs 0 (rd_data=0, mem_address=0, mem_in=0). Words in flight or queued are discarded; no done pulse.

## Timing

- Command accept to first mem_load: 1 cycle (accept edge k, mem_load high after edge k+1).
- mem_load to rd_valid: 2 cycles (rd_valid high after the edge following capture edge... i.e. visible the cycle after edge k+2).
- Sustained read throughput: 1 word/cycle with rd_ready held high.
- Write throughput: 1 word/cycle with wr_valid held high; wr accept to mem_save high: 1 cycle.
- Read command of N words with rd_ready=1: done asserted N+4 cycles after accept edge.
- Back-to-back commands: next cmd_ready one cycle after done.

## Test plan

- Read 4 words from 0x0010 (memory preloaded 0xA000+i), rd_ready=1 -> rd_data 0xA010..0xA013 in order, mem_load high 4 consecutive cycles, one done pulse.
- Write 3 words 0x1111,0x2222,0x3333 to 0x0020, then read back 3 -> memory and rd_data match; mem_save high exactly 3 cycles, never overlapping mem_load.
- Read 16 words with rd_ready toggling 1-of-3 cycles -> no FIFO overflow, no loss/duplication, mem_load throttled, all 16 words correct.
- cmd_addr=0xFFFE, len=4 read -> addresses 0xFFFE,0xFFFF,0x0000,0x0001 issued.
- cmd_len=0 (read and write) -> no mem_load/mem_save, done one cycle after accept.
- Assert rst_n low mid-read with 2 words queued -> all outputs 0 immediately, FIFO empty, no done; new command after release executes correctly.
